tse_tx_frame_gen: RTL and testbench

// - Test-frame source for the SFP link test. Sits downstream of the MAC init block and starts only after
//   mac_inited and led_link are high. Drives the TSE transmit Avalon-ST port with fixed-length Ethernet

---
 rtl/tse_tx_frame_gen.sv | 139 +++++++++++++
 tb/tb_tse_tx_frame_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tse_tx_frame_gen.sv
// Fixed-length Ethernet test-frame source for the TSE transmit Avalon-ST port.
// Each frame carries the header, a 32-bit sequence number and an incrementing byte pattern.
module tse_tx_frame_gen #(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0007_ED00_0001,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int unsigned PAYLOAD_BYTES = 46,
    parameter int unsigned GAP_CYCLES    = 12,
    parameter int unsigned MAX_FRAMES    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mac_inited,
    input  logic        led_link,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [1:0]  tx_empty,
    output logic        tx_error,
    output logic        busy,
    output logic [31:0] frame_cnt
);
    localparam int unsigned  FRAME_BYTES = 14 + PAYLOAD_BYTES;
    localparam int unsigned  FRAME_WORDS = (FRAME_BYTES + 3) / 4;
    localparam logic [1:0]   EOP_EMPTY   = 2'((4 - FRAME_BYTES % 4) % 4);
    localparam logic [8:0]   LAST_WORD   = 9'(FRAME_WORDS - 1);
    localparam logic [10:0]  FRAME_LEN   = 11'(FRAME_BYTES);
    localparam logic [15:0]  GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [111:0] HEADER      = {DST_MAC, SRC_MAC, ETHERTYPE};

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state_q, state_d;
    logic [8:0]  word_q, word_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        limit_hit, start_ok, accept, last_word;
    logic [31:0] word_data;

    // Byte idx of the frame; anything past the frame length is a zero pad lane.
    function automatic logic [7:0] frame_byte(input logic [10:0] idx, input logic [31:0] seq);
        logic [111:0] hdr_sh;
        logic [31:0]  seq_sh;
        logic [1:0]   seq_lane;
        hdr_sh   = HEADER << {idx[3:0], 3'b000};
        seq_lane = 2'(idx - 11'd14);
        seq_sh   = seq << {seq_lane, 3'b000};
        if (idx < 11'd14)
            frame_byte = hdr_sh[111:104];
        else if (idx < 11'd18)
            frame_byte = seq_sh[31:24];
        else if (idx < FRAME_LEN)
            frame_byte = 8'(idx - 11'd18);
        else
            frame_byte = 8'h00;
    endfunction

    assign word_data = {frame_byte({word_q, 2'b00}, seq_q), frame_byte({word_q, 2'b01}, seq_q),
                        frame_byte({word_q, 2'b10}, seq_q), frame_byte({word_q, 2'b11}, seq_q)};

    assign accept    = tx_valid && tx_ready;
    assign last_word = (word_q == LAST_WORD);
    assign limit_hit = (MAX_FRAMES != 0) && (run_cnt_q >= 32'(MAX_FRAMES));
    assign start_ok  = enable && mac_inited && led_link && !limit_hit;

    assign tx_valid  = (state_q == SEND);
    assign tx_data   = tx_valid ? word_data : 32'h0;
    assign tx_sop    = tx_valid && (word_q == 9'd0);
    assign tx_eop    = tx_valid && last_word;
    assign tx_empty  = tx_eop ? EOP_EMPTY : 2'b00;
    assign tx_error  = 1'b0;
    assign busy      = (state_q == SEND) || (state_q == GAP);
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        gap_d       = gap_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        run_cnt_d   = run_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SEND;
                    word_d  = '0;
                end
            end
            SEND: begin
                // Start conditions are ignored here so a started frame always completes.
                if (accept) begin
                    if (last_word) begin
                        state_d     = GAP;
                        gap_d       = '0;
                        seq_d       = seq_q + 32'd1;
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        run_cnt_d   = run_cnt_q + 32'd1;
                    end else begin
                        word_d = word_q + 9'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = start_ok ? SEND : IDLE;
                    word_d  = '0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable)
            run_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            gap_q       <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            gap_q       <= gap_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            run_cnt_q   <= run_cnt_d;
        end
    end
endmodule

// File: tb/tb_tse_tx_frame_gen.sv
// Bench for tse_tx_frame_gen: four instances (default, 47-byte, 1500-byte payload, MAX_FRAMES=3).
module tb_tse_tx_frame_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0, en3 = 1'b0, mac_inited = 1'b1, led_link = 1'b1, tx_ready = 1'b1;
    logic [31:0] data [4];
    logic        valid [4], sop [4], eop [4], err [4], busy [4];
    logic [1:0]  empty [4];
    logic [31:0] fcnt [4];

    int ntests = 0, nfail = 0, cyc = 0;
    bit rnd_rdy = 1'b0;

    typedef struct { int id; int cyc; logic [31:0] data; logic sop; logic eop; logic [1:0] empty; } rec_t;
    typedef struct { int id; int frm; int w; logic [31:0] data; logic sop; logic eop; logic [1:0] empty; } vec_t;
    rec_t mon_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) tx_ready = 1'($urandom_range(0, 1));
    end

    tse_tx_frame_gen u0 (.clk(clk), .reset(reset), .enable(enable), .mac_inited(mac_inited), .led_link(led_link),
        .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(tx_ready), .tx_sop(sop[0]), .tx_eop(eop[0]),
        .tx_empty(empty[0]), .tx_error(err[0]), .busy(busy[0]), .frame_cnt(fcnt[0]));
    tse_tx_frame_gen #(.PAYLOAD_BYTES(47)) u1 (.clk(clk), .reset(reset), .enable(enable), .mac_inited(mac_inited),
        .led_link(led_link), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(tx_ready), .tx_sop(sop[1]),
        .tx_eop(eop[1]), .tx_empty(empty[1]), .tx_error(err[1]), .busy(busy[1]), .frame_cnt(fcnt[1]));
    tse_tx_frame_gen #(.PAYLOAD_BYTES(1500)) u2 (.clk(clk), .reset(reset), .enable(enable), .mac_inited(mac_inited),
        .led_link(led_link), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(tx_ready), .tx_sop(sop[2]),
        .tx_eop(eop[2]), .tx_empty(empty[2]), .tx_error(err[2]), .busy(busy[2]), .frame_cnt(fcnt[2]));
    tse_tx_frame_gen #(.MAX_FRAMES(3)) u3 (.clk(clk), .reset(reset), .enable(en3), .mac_inited(mac_inited),
        .led_link(led_link), .tx_data(data[3]), .tx_valid(valid[3]), .tx_ready(tx_ready), .tx_sop(sop[3]),
        .tx_eop(eop[3]), .tx_empty(empty[3]), .tx_error(err[3]), .busy(busy[3]), .frame_cnt(fcnt[3]));

    // Monitor: records accepted words, checks hold-while-stalled and no bubbles inside a frame.
    bit          pv [4];
    logic [31:0] pd [4];
    logic        ps [4], pe [4];
    logic [1:0]  pm [4];
    logic        prdy = 1'b1;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && !prev_rst && pv[i]) begin
                if (!prdy) begin
                    ntests++;
                    if ({valid[i], data[i], sop[i], eop[i], empty[i]} !== {1'b1, pd[i], ps[i], pe[i], pm[i]}) begin
                        nfail++;
                        $display("FAIL stall_hold u%0d: got v=%b %h s=%b e=%b m=%0d required v=1 %h s=%b e=%b m=%0d",
                                 i, valid[i], data[i], sop[i], eop[i], empty[i], pd[i], ps[i], pe[i], pm[i]);
                    end
                end else if (!pe[i]) begin
                    ntests++;
                    if (valid[i] !== 1'b1) begin
                        nfail++;
                        $display("FAIL valid_gap u%0d: got valid=%b required 1", i, valid[i]);
                    end
                end
            end
            if (!reset && valid[i] && tx_ready)
                mon_q.push_back('{i, cyc, data[i], sop[i], eop[i], empty[i]});
            pv[i] = valid[i];
            pd[i] = data[i];
            ps[i] = sop[i];
            pe[i] = eop[i];
            pm[i] = empty[i];
        end
        prdy     = tx_ready;
        prev_rst = reset;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Index in mon_q of word w of the f-th frame (counted by sop) of instance id, -1 if absent.
    function automatic int find_idx(int id, int f, int w);
        int nf = -1;
        int wi = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].id != id) continue;
            if (mon_q[i].sop) begin nf++; wi = 0; end
            else wi++;
            if (nf == f && wi == w) return i;
        end
        return -1;
    endfunction

    function automatic int nwords(int id, int f);
        int i0 = find_idx(id, f, 0);
        int n = 0;
        if (i0 < 0) return -1;
        for (int i = i0; i < mon_q.size(); i++) begin
            if (mon_q[i].id != id) continue;
            n++;
            if (mon_q[i].eop) return n;
        end
        return -1;
    endfunction

    function automatic int nsops(int id);
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].id == id && mon_q[i].sop) n++;
        return n;
    endfunction

    // Reference for the default 46-byte payload frame, built as a byte array and then packed.
    function automatic logic [31:0] model_word(int seqv, int w);
        logic [7:0]   fb [64];
        logic [31:0]  s = seqv;
        logic [111:0] hdr = {48'hFFFF_FFFF_FFFF, 48'h0007_ED00_0001, 16'h88B5};
        for (int i = 0; i < 64; i++) fb[i] = 8'h00;
        for (int i = 0; i < 14; i++) fb[i] = 8'(hdr >> (104 - 8 * i));
        for (int i = 0; i < 4; i++) fb[14 + i] = 8'(s >> (24 - 8 * i));
        for (int k = 4; k < 46; k++) fb[14 + k] = 8'(k - 4);
        return {fb[4 * w], fb[4 * w + 1], fb[4 * w + 2], fb[4 * w + 3]};
    endfunction

    task automatic wait_fcnt(int id, int n, int budget, string nm);
        int c = 0;
        while (fcnt[id] < n && c < budget) begin @(negedge clk); c++; end
        chk({nm, "_reached"}, 64'(fcnt[id] >= n), 64'd1);
    endtask

    task automatic wait_idle(int id, int budget, string nm);
        int c = 0;
        while (busy[id] !== 1'b0 && c < budget) begin @(negedge clk); c++; end
        chk({nm, "_idle"}, 64'(busy[id]), 64'd0);
    endtask

    task automatic wait_sop(int id, int budget, string nm);
        int c = 0;
        @(negedge clk);
        while (!(valid[id] === 1'b1 && sop[id] === 1'b1) && c < budget) begin @(negedge clk); c++; end
        chk({nm, "_sop"}, 64'(sop[id]), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_word(string nm, int id, int f, int w, logic [31:0] exp);
        int ix = find_idx(id, f, w);
        chk(nm, (ix < 0) ? 64'd0 : {31'd1, mon_q[ix].data}, {31'd1, exp});
    endtask

    vec_t vt [13];
    initial begin
        bit seen;
        int ix0, ix1;
        vt[0]  = '{0, 0, 0,   32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0};
        vt[1]  = '{0, 0, 1,   32'hFFFF_0007, 1'b0, 1'b0, 2'd0};
        vt[2]  = '{0, 0, 2,   32'hED00_0001, 1'b0, 1'b0, 2'd0};
        vt[3]  = '{0, 0, 3,   32'h88B5_0000, 1'b0, 1'b0, 2'd0};
        vt[4]  = '{0, 0, 4,   32'h0000_0001, 1'b0, 1'b0, 2'd0};
        vt[5]  = '{0, 0, 5,   32'h0203_0405, 1'b0, 1'b0, 2'd0};
        vt[6]  = '{0, 0, 14,  32'h2627_2829, 1'b0, 1'b1, 2'd0};
        vt[7]  = '{0, 1, 4,   32'h0001_0001, 1'b0, 1'b0, 2'd0};
        vt[8]  = '{1, 0, 0,   32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0};
        vt[9]  = '{1, 0, 14,  32'h2627_2829, 1'b0, 1'b0, 2'd0};
        vt[10] = '{1, 0, 15,  32'h2A00_0000, 1'b0, 1'b1, 2'd3};
        vt[11] = '{2, 0, 100, 32'h7E7F_8081, 1'b0, 1'b0, 2'd0};
        vt[12] = '{2, 0, 378, 32'hD6D7_0000, 1'b0, 1'b1, 2'd2};

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i += 3) begin
            chk($sformatf("reset_ctl_u%0d", i), {valid[i], sop[i], eop[i], empty[i], err[i], busy[i]}, 64'd0);
            chk($sformatf("reset_data_u%0d", i), {data[i], fcnt[i]}, 64'd0);
        end
        reset = 1'b0;

        // Start gated by mac_inited, then by led_link
        enable = 1'b1; mac_inited = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= valid[0] | busy[0]; end
        chk("no_mac_inited", 64'(seen), 64'd0);
        mac_inited = 1'b1; led_link = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= valid[0] | busy[0]; end
        chk("no_link", 64'(seen), 64'd0);

        // Free-running frames on all three payload sizes
        mon_q.delete();
        led_link = 1'b1;
        @(negedge clk);
        chk("start_latency", {valid[0], sop[0], err[0], data[0]}, {3'b110, 32'hFFFF_FFFF});
        wait_fcnt(2, 1, 1500, "run_1500");
        enable = 1'b0;
        wait_idle(2, 1000, "run_stop");
        foreach (vt[i]) begin
            ix0 = find_idx(vt[i].id, vt[i].frm, vt[i].w);
            chk($sformatf("vec%0d", i),
                (ix0 < 0) ? 64'd0 : {28'd1, mon_q[ix0].data, mon_q[ix0].sop, mon_q[ix0].eop, mon_q[ix0].empty},
                {28'd1, vt[i].data, vt[i].sop, vt[i].eop, vt[i].empty});
        end
        chk("words_46",   64'(nwords(0, 0)), 64'd15);
        chk("words_47",   64'(nwords(1, 0)), 64'd16);
        chk("words_1500", 64'(nwords(2, 0)), 64'd379);
        ix0 = find_idx(0, 0, 14);
        ix1 = find_idx(0, 1, 0);
        chk("eop_to_sop", (ix0 < 0 || ix1 < 0) ? 64'd0 : 64'(mon_q[ix1].cyc - mon_q[ix0].cyc), 64'd13);

        // Random backpressure: stream must match the unstalled reference
        do_reset();
        mon_q.delete();
        rnd_rdy = 1'b1;
        enable = 1'b1;
        wait_fcnt(0, 2, 3000, "stall");
        enable = 1'b0;
        rnd_rdy = 1'b0;
        @(posedge clk); #2; tx_ready = 1'b1;
        wait_idle(0, 200, "stall_stop");
        chk("stall_words", 64'(nwords(0, 0)), 64'd15);
        for (int f = 0; f < 2; f++)
            for (int w = 0; w < 15; w++)
                chk_word($sformatf("stall_f%0d_w%0d", f, w), 0, f, w, model_word(f, w));

        // led_link drop mid-frame: frame completes, then idle
        do_reset();
        mon_q.delete();
        enable = 1'b1;
        wait_sop(0, 50, "linkdrop");
        repeat (7) @(negedge clk);
        led_link = 1'b0;
        wait_idle(0, 100, "linkdrop");
        chk("linkdrop_words", 64'(nwords(0, 0)), 64'd15);
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= valid[0] | busy[0]; end
        chk("linkdrop_stays_idle", 64'(seen), 64'd0);
        chk("linkdrop_fcnt", 64'(fcnt[0]), 64'd1);
        chk("linkdrop_sops", 64'(nsops(0)), 64'd1);
        enable = 1'b0; led_link = 1'b1;

        // MAX_FRAMES=3, then re-arm by toggling enable
        do_reset();
        mon_q.delete();
        en3 = 1'b1;
        repeat (120) @(negedge clk);
        chk("max_fcnt", 64'(fcnt[3]), 64'd3);
        seen = 1'b0;
        repeat (60) begin @(negedge clk); seen |= valid[3] | busy[3]; end
        chk("max_stays_idle", 64'(seen), 64'd0);
        chk("max_sops", 64'(nsops(3)), 64'd3);
        en3 = 1'b0;
        repeat (3) @(negedge clk);
        en3 = 1'b1;
        repeat (150) @(negedge clk);
        chk("max2_fcnt", 64'(fcnt[3]), 64'd6);
        chk("max2_sops", 64'(nsops(3)), 64'd6);
        chk_word("max_seq0", 3, 0, 4, 32'h0000_0001);
        for (int f = 3; f < 6; f++)
            chk_word($sformatf("max_seq%0d", f), 3, f, 4, {16'(f), 16'h0001});
        en3 = 1'b0;

        // Reset mid-frame (second frame, word 5)
        do_reset();
        mon_q.delete();
        enable = 1'b1;
        wait_fcnt(0, 1, 100, "rst_pre");
        wait_sop(0, 50, "rst_pre");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", {valid[0], busy[0], sop[0]}, 64'd0);
        chk("rst_mid_fcnt", 64'(fcnt[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mon_q.delete();
        wait_sop(0, 20, "rst_post");
        repeat (10) @(negedge clk);
        chk_word("rst_post_w0", 0, 0, 0, 32'hFFFF_FFFF);
        chk_word("rst_post_w3", 0, 0, 3, 32'h88B5_0000);
        chk_word("rst_post_seq0", 0, 0, 4, 32'h0000_0001);
        enable = 1'b0;
        wait_idle(0, 100, "final");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end
endmodule
